sample_stream_fifo: RTL and testbench

//   Parametrised ready/valid stream buffer for the cocotb test designs. Generalises
//   the single-register stream path to DATA_WIDTH-bit beats through a DEPTH-entry FIFO.

---
 rtl/sample_stream_fifo.sv | 149 ++++++++++++++
 tb/tb_sample_stream_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sample_stream_fifo.sv
// Ready/valid stream FIFO with DEPTH entries, occupancy level, almost-full flag and synchronous flush.
// Define SAMPLE_FIFO_STATS_EN to add the 32-bit accepted/delivered beat counters.
module sample_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          stream_in_valid,
    output logic                          stream_in_ready,
    input  logic [DATA_WIDTH-1:0]         stream_in_data,
    output logic                          stream_out_valid,
    input  logic                          stream_out_ready,
    output logic [DATA_WIDTH-1:0]         stream_out_data,
    output logic [$clog2(DEPTH+1)-1:0]    stream_level,
    output logic                          stream_almost_full
`ifdef SAMPLE_FIFO_STATS_EN
   ,output logic [31:0]                   stat_in_count,
    output logic [31:0]                   stat_out_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  af_q, af_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  push_s, pop_s;

    // Next-state computation; the head register is refreshed from storage, or from the input when the new beat becomes head.
    always_comb begin
        push_s      = stream_in_valid & in_ready_q & ~flush;
        pop_s       = out_valid_q & stream_out_ready & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        if (flush || (level_d == {LW{1'b0}})) begin
            out_data_d = out_data_q;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = stream_in_data;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
        in_ready_d  = (level_d != DEPTH_L);
        out_valid_d = (level_d != {LW{1'b0}});
        af_d        = (level_d >= AF_L);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {LW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            out_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage array, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= stream_in_data;
        end
    end

    assign stream_in_ready    = in_ready_q;
    assign stream_out_valid   = out_valid_q;
    assign stream_out_data    = out_data_q;
    assign stream_level       = level_q;
    assign stream_almost_full = af_q;

`ifdef SAMPLE_FIFO_STATS_EN
    logic [31:0] stat_in_count_q, stat_in_count_d;
    logic [31:0] stat_out_count_q, stat_out_count_d;

    // Beat counters wrap naturally and ignore flush.
    always_comb begin
        if (push_s) begin
            stat_in_count_d = stat_in_count_q + 32'd1;
        end else begin
            stat_in_count_d = stat_in_count_q;
        end
        if (pop_s) begin
            stat_out_count_d = stat_out_count_q + 32'd1;
        end else begin
            stat_out_count_d = stat_out_count_q;
        end
    end

    // Counter registers, cleared by reset only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_in_count_q  <= 32'd0;
            stat_out_count_q <= 32'd0;
        end else begin
            stat_in_count_q  <= stat_in_count_d;
            stat_out_count_q <= stat_out_count_d;
        end
    end

    assign stat_in_count  = stat_in_count_q;
    assign stat_out_count = stat_out_count_q;
`endif

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Directed self-checking bench for sample_stream_fifo (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3).
module tb_sample_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       almost_full;
`ifdef SAMPLE_FIFO_STATS_EN
    logic [31:0] stat_in;
    logic [31:0] stat_out;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .stream_in_valid    (in_valid),
        .stream_in_ready    (in_ready),
        .stream_in_data     (in_data),
        .stream_out_valid   (out_valid),
        .stream_out_ready   (out_ready),
        .stream_out_data    (out_data),
        .stream_level       (level),
        .stream_almost_full (almost_full)
`ifdef SAMPLE_FIFO_STATS_EN
       ,.stat_in_count      (stat_in),
        .stat_out_count     (stat_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_vec++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_vec++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", almost_full); end
        n_vec++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    endtask

    task automatic test_fill();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = d[i];
            tick();
            n_vec++; if (level !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, i + 1); end
            n_vec++; if (almost_full !== exp_af[i]) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, exp_af[i]); end
            n_vec++; if (in_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, in_ready, exp_rdy[i]); end
            n_vec++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_head[%0d] got=%h/%b exp=11/1", i, out_data, out_valid); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_backpressure();
        logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h55};
        in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        tick();
        n_vec++; if (level !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop got=%0d/%b exp=3/1", level, in_ready); end
        n_vec++; if (out_data !== 8'h22) begin n_fail++; $display("FAIL bp_head got=%h exp=22", out_data); end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_vec++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_push got=%0d/%b exp=4/0", level, in_ready); end
        n_vec++; if (out_data !== 8'h22) begin n_fail++; $display("FAIL bp_stable got=%h exp=22", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_data !== exp[i] || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, level); end
        n_vec++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL drain_hold got=%h exp=55", out_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        in_valid = 1'b1;
        in_data = 8'hA0; tick();
        in_data = 8'hA1; tick();
        exp_q = '{8'hA0, 8'hA1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            exp_q.push_back(8'(i));
            n_vec++; if (out_data !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
            n_vec++; if (level !== 3'd2) begin n_fail++; $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level); end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_data !== 8'h08) begin n_fail++; $display("FAIL b2b_tail got=%h exp=08", out_data); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 8'h0A;
        tick();
        n_vec++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush_pre got=%0d exp=3", level); end
        flush = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1", level, out_valid, in_ready); end
        n_vec++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_af got=%b exp=0", almost_full); end
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_data !== 8'h5A || level !== 3'd1) begin n_fail++; $display("FAIL flush_after got=%h/%0d exp=5a/1", out_data, level); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_data = 8'h66;
        tick();
        in_valid = 1'b0;
        n_vec++; if (level !== 3'd2) begin n_fail++; $display("FAIL arst_pre got=%0d exp=2", level); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_async got=%b/%0d/%b exp=0/0/1", out_valid, level, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (level !== 3'd0 || out_data !== 8'h00) begin n_fail++; $display("FAIL arst_after got=%0d/%h exp=0/00", level, out_data); end
    endtask

`ifdef SAMPLE_FIFO_STATS_EN
    task automatic test_stats();
        force dut.stat_in_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stat_in_count_q;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (stat_in !== 32'd1) begin n_fail++; $display("FAIL stat_in got=%h exp=00000001", stat_in); end
        n_vec++; if (stat_out !== 32'd2) begin n_fail++; $display("FAIL stat_out got=%h exp=00000002", stat_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_full_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef SAMPLE_FIFO_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
